mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_word_ram.sv | 34 +++
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder: state encoding, bus widths
// and the byte-address to word-index mapping.
package mem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte address to word index; the caller keeps only the low ADDR_W bits.
    function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU data port (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_word_ram.sv
// 2**ADDR_W x 32 word RAM, one byte-wide block per lane so each byte enable
// maps onto its own write port; synchronous write and registered read.
module mem_word_ram
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wd[8*gi +: 8];
                end
                lane_rd_reg <= lane_mem[addr];
            end

            assign rd[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts one word request, waits LATENCY cycles,
// commits to the word RAM and holds the response until consumed. Optional
// address checking is enabled by defining MEM_RESP_ERR_CHECK_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic                req_ready_reg;
    logic                resp_valid_reg;
    logic                resp_read_reg;
    logic                resp_err_reg;

    logic                write_reg;
    logic                err_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic [BE_W-1:0]     be_reg;

    logic [WORD_W-1:0]   word_full;
    logic [ADDR_W-1:0]   in_idx;
    logic                in_err;
    logic                accept;
    logic                commit;
    logic                cur_write;
    logic                cur_err;
    logic                ram_we;
    logic [BE_W-1:0]     ram_be;
    logic [ADDR_W-1:0]   ram_addr;
    logic [WORD_W-1:0]   ram_wd;
    logic [WORD_W-1:0]   ram_rd;
    logic                unused_word_bits;

    assign word_full        = word_index(bus.req_addr);
    assign in_idx           = word_full[ADDR_W-1:0];
    assign unused_word_bits = ^word_full[WORD_W-1:ADDR_W];

`ifdef MEM_RESP_ERR_CHECK_EN
    assign in_err = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> (ADDR_W + 2)) != '0);
`else
    assign in_err = 1'b0;
`endif

    // req_ready is only ever high in IDLE, so this is the accept strobe.
    assign accept = req_ready_reg && bus.req_valid;
    assign commit = ZERO_LAT ? accept : ((state_reg == WAIT) && (cnt_reg == 4'd1));

    // With no wait states the RAM is driven straight from the request on the accept edge.
    always_comb begin
        ram_addr  = idx_reg;
        ram_wd    = wdata_reg;
        ram_be    = be_reg;
        cur_write = write_reg;
        cur_err   = err_reg;
        if (ZERO_LAT && accept) begin
            ram_addr  = in_idx;
            ram_wd    = bus.req_wdata;
            ram_be    = bus.req_be;
            cur_write = bus.req_write;
            cur_err   = in_err;
        end
    end

    assign ram_we = commit && cur_write && !cur_err && !reset;

    mem_word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .wd   (ram_wd),
        .rd   (ram_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_read_reg  <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        write_reg     <= bus.req_write;
                        idx_reg       <= in_idx;
                        wdata_reg     <= bus.req_wdata;
                        be_reg        <= bus.req_be;
                        err_reg       <= in_err;
                        cnt_reg       <= LAT_LOAD;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ZERO_LAT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_reg     <= IDLE;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (commit) begin
                resp_valid_reg <= 1'b1;
                resp_read_reg  <= !cur_write && !cur_err;
                resp_err_reg   <= cur_err;
            end else if ((state_reg == RESP) && bus.resp_ready) begin
                resp_valid_reg <= 1'b0;
                resp_read_reg  <= 1'b0;
                resp_err_reg   <= 1'b0;
            end
        end
    end

    // The RAM keeps re-reading the latched word while in RESP; nothing writes it
    // then, so the read data stays stable until the handshake.
    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.resp_rdata = resp_read_reg ? ram_rd : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: a LATENCY=2 instance and a
// LATENCY=0 instance checked against a word-array reference model.
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int LAT_A = 2;
    localparam int TO    = 40;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_responder_if bus_a();
    mem_responder_if bus_b();

    mem_responder #(.ADDR_W(AW), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mem_responder #(.ADDR_W(AW), .LATENCY(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_mem   [2][DEPTH];
    logic [3:0]  mdl_known [2][DEPTH];

    bit          p_wr;
    logic [31:0] p_addr;
    logic [31:0] p_wd;
    logic [3:0]  p_be;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] a);
`ifdef MEM_RESP_ERR_CHECK_EN
        return (a % 32'd4 != 32'd0) || (a >= 32'(DEPTH * 4));
`else
        return (a != a);
`endif
    endfunction

    // Applies one request to the model; returns expected read data, a mask of
    // bytes whose value is defined, and the expected error flag.
    task automatic model_apply(input int d, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be,
                               output logic [31:0] rd, output logic [31:0] mask,
                               output bit err);
        int i;
        err  = exp_err(a);
        i    = int'((a / 32'd4) % 32'(DEPTH));
        rd   = '0;
        mask = '1;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mdl_mem[d][i][8*b +: 8] = wd[8*b +: 8];
                        mdl_known[d][i][b]      = 1'b1;
                    end
                end
            end else begin
                rd = mdl_mem[d][i];
                for (int b = 0; b < 4; b++) begin
                    mask[8*b +: 8] = mdl_known[d][i][b] ? 8'hFF : 8'h00;
                end
            end
        end
    endtask

    task automatic issue_a(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        int n = 0;
        @(negedge clk);
        bus_a.req_valid = 1'b1;
        bus_a.req_write = wr;
        bus_a.req_addr  = a;
        bus_a.req_wdata = wd;
        bus_a.req_be    = be;
        while (bus_a.req_ready !== 1'b1 && n < TO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TO) check("a_accept_timeout", 32'(bus_a.req_ready), 32'd1);
        @(posedge clk);
        p_wr = wr; p_addr = a; p_wd = wd; p_be = be;
    endtask

    task automatic collect_a(input int stall);
        logic [31:0] erd, emask, seen;
        bit eerr;
        int n;
        model_apply(0, p_wr, p_addr, p_wd, p_be, erd, emask, eerr);
        @(negedge clk);
        // A junk write held on the bus while busy must never be taken.
        bus_a.req_valid = 1'b1;
        bus_a.req_write = 1'b1;
        bus_a.req_addr  = 32'($urandom_range(0, 63)) << 2;
        bus_a.req_wdata = $urandom;
        bus_a.req_be    = 4'hF;
        check("a_busy_ready", 32'(bus_a.req_ready), 32'd0);
        n = 1;
        while (bus_a.resp_valid !== 1'b1 && n < TO) begin
            @(negedge clk);
            n++;
        end
        check("a_latency", 32'(n), 32'(LAT_A + 1));
        check("a_rdata", bus_a.resp_rdata & emask, erd & emask);
        check("a_err", 32'(bus_a.resp_err), 32'(eerr));
        seen = bus_a.resp_rdata;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("a_stall_valid", 32'(bus_a.resp_valid), 32'd1);
            check("a_stall_ready", 32'(bus_a.req_ready), 32'd0);
            check("a_stall_rdata", bus_a.resp_rdata & emask, erd & emask);
        end
        bus_a.resp_ready = 1'b1;
        bus_a.req_valid  = 1'b0;
        @(negedge clk);
        check("a_post_valid", 32'(bus_a.resp_valid), 32'd0);
        check("a_post_ready", 32'(bus_a.req_ready), 32'd1);
        bus_a.resp_ready = 1'b0;
        $display("txn a %s addr=%h wdata=%h be=%h rdata=%h exp=%h err=%0d stall=%0d",
                 p_wr ? "WR" : "RD", p_addr, p_wd, p_be, seen, erd, eerr, stall);
    endtask

    task automatic txn_b(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
        logic [31:0] erd, emask;
        bit eerr;
        int n = 0;
        @(negedge clk);
        bus_b.req_valid = 1'b1;
        bus_b.req_write = wr;
        bus_b.req_addr  = a;
        bus_b.req_wdata = wd;
        bus_b.req_be    = be;
        while (bus_b.req_ready !== 1'b1 && n < TO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TO) check("b_accept_timeout", 32'(bus_b.req_ready), 32'd1);
        @(posedge clk);
        model_apply(1, wr, a, wd, be, erd, emask, eerr);
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        check("b_lat0_valid", 32'(bus_b.resp_valid), 32'd1);
        check("b_busy_ready", 32'(bus_b.req_ready), 32'd0);
        check("b_rdata", bus_b.resp_rdata & emask, erd & emask);
        check("b_err", 32'(bus_b.resp_err), 32'(eerr));
        $display("txn b %s addr=%h wdata=%h be=%h rdata=%h exp=%h err=%0d",
                 wr ? "WR" : "RD", a, wd, be, bus_b.resp_rdata, erd, eerr);
        bus_b.resp_ready = 1'b1;
        @(negedge clk);
        check("b_post_valid", 32'(bus_b.resp_valid), 32'd0);
        check("b_post_ready", 32'(bus_b.req_ready), 32'd1);
        bus_b.resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] erd, emask, rv, a, wd;
        bit eerr, wr;
        int n, r;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mdl_known[d][i] = 4'h0;
        end
        bus_a.req_valid = 0; bus_a.req_write = 0; bus_a.req_addr = 0;
        bus_a.req_wdata = 0; bus_a.req_be = 0; bus_a.resp_ready = 0;
        bus_b.req_valid = 0; bus_b.req_write = 0; bus_b.req_addr = 0;
        bus_b.req_wdata = 0; bus_b.req_be = 0; bus_b.resp_ready = 0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
        check("rst_rdata", bus_a.resp_rdata, 32'd0);
        check("rst_err", 32'(bus_a.resp_err), 32'd0);
        check("rst_b_ready", 32'(bus_b.req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 32'(bus_a.req_ready), 32'd1);

        // Write then read back.
        issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF); collect_a(0);
        issue_a(1'b0, 32'h10, 32'h0, 4'h0);        collect_a(0);

        // Byte-enable merge: expect 11BB33DD.
        issue_a(1'b1, 32'h20, 32'h11223344, 4'hF); collect_a(0);
        issue_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101); collect_a(1);
        issue_a(1'b0, 32'h20, 32'h0, 4'h0);        collect_a(0);

        // Backpressure for 5 cycles.
        issue_a(1'b0, 32'h20, 32'h0, 4'h0);        collect_a(5);

        // Reset while waiting aborts the write.
        issue_a(1'b1, 32'h30, 32'h11223344, 4'hF); collect_a(0);
        issue_a(1'b1, 32'h30, 32'h00000055, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        bus_a.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", 32'(bus_a.resp_valid), 32'd0);
        issue_a(1'b0, 32'h30, 32'h0, 4'h0);        collect_a(0);

        // Reset while responding drops the response but keeps the write.
        rv = $urandom;
        issue_a(1'b1, 32'h40, rv, 4'hF);
        model_apply(0, 1'b1, 32'h40, rv, 4'hF, erd, emask, eerr);
        n = 0;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        while (bus_a.resp_valid !== 1'b1 && n < TO) begin
            @(negedge clk);
            n++;
        end
        check("resp_before_reset", 32'(bus_a.resp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_drop_valid", 32'(bus_a.resp_valid), 32'd0);
        check("reset_drop_rdata", bus_a.resp_rdata, 32'd0);
        issue_a(1'b0, 32'h40, 32'h0, 4'h0);        collect_a(0);

        // Misaligned and out-of-range addresses.
        issue_a(1'b1, 32'h0, 32'h01020304, 4'hF);  collect_a(0);
        issue_a(1'b0, 32'h13, 32'h0, 4'h0);        collect_a(0);
        issue_a(1'b1, 32'(1) << (AW + 2), 32'hCAFEF00D, 4'hF); collect_a(0);
        issue_a(1'b0, 32'h0, 32'h0, 4'h0);         collect_a(0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            if (r < 8)       a = 32'($urandom_range(0, 15)) << 2;
            else if (r == 8) a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
            else             a = $urandom;
            wd = $urandom;
            issue_a(wr, a, wd, 4'($urandom_range(0, 15)));
            collect_a(int'($urandom_range(0, 3)));
        end

        // Zero-latency instance: single transactions then back-to-back reads.
        txn_b(1'b1, 32'h8, 32'h5A5AA5A5, 4'hF);
        txn_b(1'b0, 32'h8, 32'h0, 4'h0);
        txn_b(1'b1, 32'hC, 32'h12345678, 4'b0011);
        txn_b(1'b0, 32'hC, 32'h0, 4'h0);
        model_apply(1, 1'b0, 32'h8, 32'h0, 4'h0, erd, emask, eerr);
        @(negedge clk);
        bus_b.req_valid  = 1'b1;
        bus_b.req_write  = 1'b0;
        bus_b.req_addr   = 32'h8;
        bus_b.resp_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("b_b2b_valid", 32'(bus_b.resp_valid), 32'(k % 2));
            if (k % 2 == 1) check("b_b2b_rdata", bus_b.resp_rdata & emask, erd & emask);
            $display("txn b b2b cycle=%0d valid=%0d rdata=%h", k, bus_b.resp_valid, bus_b.resp_rdata);
        end
        bus_b.req_valid  = 1'b0;
        bus_b.resp_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
